// File: rtl/ciu_issue_arbiter.sv
// ============================================================================
// Module   : ciu_issue_arbiter
// Brief    : Round-robin sharing of one CIU between two requesters, single op
//            in flight, opcode range check, fixed-latency result capture.
//            Optional CIU_ARB_PERF_EN adds the 16-bit issue_cnt port/counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ciu_issue_arbiter #(
    parameter int DW      = 19,
    parameter int OPW     = 4,
    parameter int LATENCY = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_op,
    input  logic [DW-1:0]  req0_a,
    input  logic [DW-1:0]  req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_op,
    input  logic [DW-1:0]  req1_a,
    input  logic [DW-1:0]  req1_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [DW-1:0]  rsp_data,
    output logic           rsp_err,
    output logic [OPW-1:0] ciu_opcode,
    output logic [DW-1:0]  ciu_r1,
    output logic [DW-1:0]  ciu_r2,
    input  logic [DW-1:0]  ciu_result,
`ifdef CIU_ARB_PERF_EN
    output logic [15:0]    issue_cnt,
`endif
    output logic           busy
);

    localparam logic [OPW-1:0] C_OP_MAX  = OPW'(7);
    localparam logic [3:0]     C_LAT_M1  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_rr_ptr;
    logic           r_gnt_seen;
    logic [OPW-1:0] r_op;
    logic [DW-1:0]  r_a;
    logic [DW-1:0]  r_b;
    logic [DW-1:0]  r_data;
    logic           r_id;
    logic           r_err;
    logic [3:0]     r_cnt;

    logic           w_win;
    logic           w_accept;
    logic           w_op_ok;
    logic [OPW-1:0] w_sel_op;
    logic [DW-1:0]  w_sel_a;
    logic [DW-1:0]  w_sel_b;

    // Until the first grant req0 is preferred; afterwards the last granted loses ties.
    always_comb begin
        w_win = req1_valid;
        if (req0_valid && req1_valid) begin
            w_win = r_gnt_seen ? ~r_rr_ptr : 1'b0;
        end
    end

    assign w_accept   = (r_state == S_IDLE) && (req0_valid || req1_valid);
    assign req0_ready = w_accept && !w_win;
    assign req1_ready = w_accept && w_win;
    assign w_sel_op   = w_win ? req1_op : req0_op;
    assign w_sel_a    = w_win ? req1_a  : req0_a;
    assign w_sel_b    = w_win ? req1_b  : req0_b;
    assign w_op_ok    = (w_sel_op != '0) && (w_sel_op <= C_OP_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ciu_opcode  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_op_ok ? S_ISSUE : S_RESP;
                end
            end
            S_ISSUE: begin
                ciu_opcode  = r_op;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= 1'b0;
            r_gnt_seen <= 1'b0;
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_id       <= 1'b0;
            r_err      <= 1'b0;
            r_data     <= '0;
            r_cnt      <= 4'd0;
        end else begin
            if (w_accept) begin
                r_op       <= w_sel_op;
                r_a        <= w_sel_a;
                r_b        <= w_sel_b;
                r_id       <= w_win;
                r_rr_ptr   <= w_win;
                r_gnt_seen <= 1'b1;
                r_err      <= !w_op_ok;
                r_data     <= '0;
            end
            if (r_state == S_ISSUE) begin
                r_cnt <= C_LAT_M1;
            end else if (r_state == S_WAIT) begin
                if (r_cnt == 4'd0) begin
                    r_data <= ciu_result;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
        end
    end

`ifdef CIU_ARB_PERF_EN
    logic [15:0] r_issue_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_cnt <= 16'd0;
        end else if (r_state == S_ISSUE) begin
            r_issue_cnt <= r_issue_cnt + 16'd1;
        end
    end

    assign issue_cnt = r_issue_cnt;
`endif

    assign rsp_valid = (r_state == S_RESP);
    assign rsp_id    = r_id;
    assign rsp_data  = r_data;
    assign rsp_err   = r_err;
    assign ciu_r1    = r_a;
    assign ciu_r2    = r_b;
    assign busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ciu_issue_arbiter.sv
// ============================================================================
// Module   : tb_ciu_issue_arbiter
// Brief    : Scoreboard bench for ciu_issue_arbiter with a CIU model whose
//            result is valid only exactly LAT cycles after the issue edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ciu_issue_arbiter;

    localparam int DW  = 19;
    localparam int OPW = 4;
    localparam int LAT = 4;

    typedef struct packed {
        logic          id;
        logic          err;
        logic [DW-1:0] data;
    } rsp_t;

    typedef struct packed {
        logic [OPW-1:0] op;
        logic [DW-1:0]  a;
        logic [DW-1:0]  b;
    } iss_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req0_valid = 1'b0, req1_valid = 1'b0;
    logic           req0_ready, req1_ready;
    logic [OPW-1:0] req0_op = '0, req1_op = '0;
    logic [DW-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic           rsp_valid, rsp_id, rsp_err;
    logic           rsp_ready = 1'b1;
    logic [DW-1:0]  rsp_data;
    logic [OPW-1:0] ciu_opcode;
    logic [DW-1:0]  ciu_r1, ciu_r2, ciu_result;
    logic           busy;
`ifdef CIU_ARB_PERF_EN
    logic [15:0]    issue_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;
    rsp_t rsp_q[$];
    iss_t iss_q[$];

    always #5 clk = ~clk;

    ciu_issue_arbiter #(.DW(DW), .OPW(OPW), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .ciu_opcode (ciu_opcode),
        .ciu_r1     (ciu_r1),
        .ciu_r2     (ciu_r2),
        .ciu_result (ciu_result),
`ifdef CIU_ARB_PERF_EN
        .issue_cnt  (issue_cnt),
`endif
        .busy       (busy)
    );

    function automatic logic [DW-1:0] ciu_f(input logic [OPW-1:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        return DW'(a * DW'(op) + b);
    endfunction

    // CIU model: the true result appears only in the single cycle LAT edges after issue.
    int            cyc = 0;
    int            iss_cyc = -100;
    logic [DW-1:0] m_val = '0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ciu_opcode != '0) begin
            iss_cyc <= cyc;
            m_val   <= ciu_f(ciu_opcode, ciu_r1, ciu_r2);
        end
    end
    assign ciu_result = (cyc == iss_cyc + LAT) ? m_val : ~m_val;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_push(input logic id, input logic [OPW-1:0] op, input logic [DW-1:0] a,
                            input logic [DW-1:0] b);
        logic err;
        err = (op == '0) || (op > 4'd7);
        rsp_q.push_back('{id: id, err: err, data: err ? '0 : ciu_f(op, a, b)});
        if (!err) iss_q.push_back('{op: op, a: a, b: b});
    endtask

    task automatic drive(input logic id, input logic v, input logic [OPW-1:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (id) begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    // Presents one op, waits (bounded) for its grant, then scrambles the inputs.
    task automatic send(input logic id, input logic [OPW-1:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        drive(id, 1'b1, op, a, b);
        for (int t = 0; t < 60 && !got; t++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) got = 1'b1;
        end
        chk("grant", 64'(got), 64'd1);
        if (got) exp_push(id, op, a, b);
        @(posedge clk); #1;
        drive(id, 1'b0, 4'hF, ~a, ~b);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (rsp_q.size() == 0 && !busy) done = 1'b1;
        end
        chk("drain", {62'd0, done, 1'(iss_q.size() == 0)}, 64'd3);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        rsp_q.delete();
        iss_q.delete();
        #1;
        chk("rst_async", {busy, rsp_valid, ciu_opcode}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    logic [OPW-1:0] c0_op[3] = '{4'd1, 4'd2, 4'd3};
    logic [OPW-1:0] c1_op[3] = '{4'd7, 4'd5, 4'd4};

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    if (ciu_opcode != '0) begin
                        if (iss_q.size() == 0) begin
                            chk("issue_unexpected", 64'(ciu_opcode), 64'd0);
                        end else begin
                            iss_t e;
                            e = iss_q.pop_front();
                            chk("issue", {ciu_opcode, ciu_r1, ciu_r2}, e);
                        end
                    end
                    if (rsp_valid && rsp_ready) begin
                        if (rsp_q.size() == 0) begin
                            chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
                        end else begin
                            rsp_t r;
                            r = rsp_q.pop_front();
                            chk("rsp", {rsp_id, rsp_err, rsp_data}, r);
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_state", {busy, rsp_valid, req0_ready, req1_ready, rsp_id, rsp_err, ciu_opcode,
                            ciu_r1, ciu_r2}, '0);
        chk("reset_data", 64'(rsp_data), 64'd0);
`ifdef CIU_ARB_PERF_EN
        chk("reset_cnt", 64'(issue_cnt), 64'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single op from req0
        send(1'b0, 4'h6, 19'd3, 19'd5);
        drain();

        // Rejected opcode: response visible the cycle after accept
        send(1'b1, 4'h9, 19'd11, 19'd12);
        chk("reject_next", {rsp_valid, rsp_id, rsp_err, rsp_data}, {3'b111, 19'd0});
        drain();
        send(1'b0, 4'h0, 19'd1, 19'd2);
        drain();

        // Contention from reset: grants alternate 0,1,0,1,...
        do_reset();
        @(posedge clk); #1;
        drive(1'b0, 1'b1, c0_op[0], 19'd100, 19'd1);
        drive(1'b1, 1'b1, c1_op[0], 19'd200, 19'd2);
        begin
            int i0, i1;
            i0 = 0; i1 = 0;
            for (int k = 0; k < 6; k++) begin
                bit got;
                logic gid;
                got = 1'b0;
                for (int t = 0; t < 40 && !got; t++) begin
                    @(negedge clk);
                    if (req0_ready || req1_ready) got = 1'b1;
                end
                chk("cont_grant", 64'(got), 64'd1);
                if (!got) break;
                gid = req1_ready;
                chk("cont_order", 64'(gid), 64'(k % 2));
                chk("cont_onehot", 64'(req0_ready & req1_ready), 64'd0);
                if (gid) exp_push(1'b1, req1_op, req1_a, req1_b);
                else     exp_push(1'b0, req0_op, req0_a, req0_b);
                @(posedge clk); #1;
                if (gid) begin
                    i1++;
                    if (i1 < 3) drive(1'b1, 1'b1, c1_op[i1], DW'(200 + i1), DW'(2 + i1));
                    else        drive(1'b1, 1'b0, '0, '0, '0);
                end else begin
                    i0++;
                    if (i0 < 3) drive(1'b0, 1'b1, c0_op[i0], DW'(100 + i0), DW'(1 + i0));
                    else        drive(1'b0, 1'b0, '0, '0, '0);
                end
            end
        end
        drain();

        // Backpressure: 10 stalled cycles with req1 pending
        rsp_ready = 1'b0;
        send(1'b0, 4'h3, 19'h7FFFF, 19'd9);
        begin
            bit seen;
            seen = 1'b0;
            for (int t = 0; t < 40 && !seen; t++) begin
                @(negedge clk);
                if (rsp_valid) seen = 1'b1;
            end
            chk("bp_valid", 64'(seen), 64'd1);
        end
        drive(1'b1, 1'b1, 4'h2, 19'd40, 19'd41);
        repeat (10) begin
            @(negedge clk);
            chk("bp_hold", {rsp_valid, rsp_id, rsp_err, req0_ready, req1_ready, rsp_data},
                {5'b10000, ciu_f(4'h3, 19'h7FFFF, 19'd9)});
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        send(1'b1, 4'h2, 19'd40, 19'd41);
        drain();

        // Reset while waiting for the CIU result
        send(1'b0, 4'h2, 19'd50, 19'd51);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_busy", 64'(busy), 64'd1);
        do_reset();
        send(1'b0, 4'h5, 19'd60, 19'd61);
        drain();

`ifdef CIU_ARB_PERF_EN
        send(1'b1, 4'h7, 19'd70, 19'd71);
        drain();
        send(1'b1, 4'hC, 19'd72, 19'd73);
        drain();
        send(1'b0, 4'h1, 19'd74, 19'd75);
        drain();
        chk("issue_cnt", 64'(issue_cnt), 64'd3);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
